sync_fifo: RTL
==============

# sync_fifo

Synchronous single-clock FIFO that is the design under test behind `fifo_if`. It responds to the `rd_en`/`wr_en`/`data_in` strobes from the bench driver and returns `full`, `empty` and `data_out`. All outputs are registered, so the monitor clocking block sees one coherent sample per rising edge.

## Interface
- `DATA_WIDTH`, 8, width of each stored word.
- `DEPTH`, 16, number of entries. Must be a power of two and at least 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous reset, active-high.
- `wr_en`  input  1  write request.
- `data_in`  input  DATA_WIDTH  write data, sampled with `wr_en`.
- `rd_en`  input  1  read request.
- `data_out`  output  DATA_WIDTH  last word read; registered.
- `full`  output  1  occupancy == DEPTH; registered.
- `empty`  output  1  occupancy == 0; registered.
- `overflow`  output  1  sticky error flag. Present only with `SYNC_FIFO_ERR_FLAGS_EN`.
- `underflow`  output  1  sticky error flag. Present only with `SYNC_FIFO_ERR_FLAGS_EN`.

## Operation
- **Clocking and reset.** One clock (`clk`). Reset is synchronous and active-high (`rst`).
- **Reset values.** While `rst` is high at a rising edge:
  - write pointer, read pointer and count go to 0;
  - `empty`=1, `full`=0, `data_out`=0;
  - `overflow`=0 and `underflow`=0 (if compiled in).
- **Reset mid-operation.** Reset discards all contents. Memory array is not cleared, but old words are unreachable. Reset has priority over `rd_en`/`wr_en` on the same edge.
- **Write acceptance.** A write is accepted iff `wr_en && !full` at the edge. The word goes to `mem[wr_ptr]` and `wr_ptr` increments.
- **Read acceptance.** A read is accepted iff `rd_en && !empty` at the edge. `mem[rd_ptr]` goes to `data_out` and `rd_ptr` increments.
- **Rejected requests.** A rejected write (full) or rejected read (empty) changes no state. `data_out` holds its value.
- **Simultaneous read and write.**
  - Neither full nor empty: both are accepted and count is unchanged.
  - Empty: only the write is accepted. `data_out` is unchanged. The new word is readable from the next cycle.
  - Full: only the read is accepted, and count drops to DEPTH-1.
- **Pointers.** Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. There is no special wrap handling.
- **Count.** Count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - `full` and `empty` are registered from next-count: `full_q <= (count_next == DEPTH)`, `empty_q <= (count_next == 0)`.
  - They are never both 1.
- **`data_out` when not reading.** `data_out` holds the last read value. It is not a look-ahead (non-FWFT).

## Timing
- **Write to `empty` deassertion.** Write accepted at edge N leads to `empty`=0 after edge N. The bench samples it at edge N+1.
- **Read latency.** Read accepted at edge N puts the word on `data_out` after edge N. The monitor sees it at edge N+1. Latency is 1 cycle.
- **First-word fall-through.** Minimum write-to-read-data is 2 edges: write at N, read at N+1, data valid after N+1.
- **Throughput.** One write and one read per cycle, sustained.
- **Flag update.** `full` and `empty` change only on the edge where count changes. There are no combinational paths from inputs to outputs.

## Configuration
- **Macro.** `SYNC_FIFO_ERR_FLAGS_EN`.
- **Defined.**
  - `overflow` and `underflow` ports exist.
  - `overflow` sets on the edge after `wr_en && full && !rst`.
  - `underflow` sets on the edge after `rd_en && empty && !rst`.
  - Both stay set until `rst`.
  - Rejected-request behaviour is otherwise identical.
- **Not defined.** The ports and their logic are absent, and rejected requests are silently ignored.

## Structure
- **Package `fifo_pkg`.**
  - `DATA_WIDTH` default (8) and `DEPTH` default (16).
  - `localparam PTR_W = $clog2(DEPTH)` and `CNT_W = PTR_W+1`.
  - `typedef logic [DATA_WIDTH-1:0] fifo_data_t`.
  - These are shared with the `fifo_if` users and the UVM env.
- **Sub-module `fifo_mem`.**
  - Dual-port register array: one write port, one synchronous read port.
  - Carries no flags.
  - `sync_fifo` holds the pointers, count, flag registers and error flags.

## Test plan
- **Reset then idle.** Hold `rst` 2 cycles, then idle 4 cycles. Expect `empty`=1, `full`=0, `data_out`=0 throughout.
- **Fill and drain.** Write 0x01..0x10 (16 words, DEPTH=16).
  - `full`=1 is seen at the edge after the 16th write.
  - A 17th write of 0xFF is ignored.
  - Reading 16 words returns 0x01..0x10 in order, each one cycle after its read.
  - `empty`=1 after the last read.
- **Underflow.** Assert `rd_en` while empty. `data_out` keeps its prior value and the pointers are unchanged. With the macro, `underflow`=1 and stays 1 until `rst`.
- **Simultaneous read/write at boundaries.**
  - At count=16: `rd_en`+`wr_en` with 0xAA. Expect read data 0x01 (the oldest word), write rejected, count 15, `full`=0.
  - At count=0: `rd_en`+`wr_en` with 0x55. Expect count 1, `data_out` unchanged, 0x55 read on the next read.
- **Wrap-around.** Stream 40 words with `rd_en` and `wr_en` both high each cycle after a 3-word prefill. Expect output order equal to input order, count constant at 3, no flag toggles.
- **Reset mid-operation.** With count=9, assert `rst` together with `wr_en`=1. Expect count 0, `empty`=1, `data_out`=0. The next read after one write returns only the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults: word width, depth and the derived pointer/count widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef logic [DATA_WIDTH-1:0] fifo_data_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage for sync_fifo: register array with one write port and one registered read port.
// Latency: write visible to a read on the next edge; read data appears one edge after re.
// Backpressure: none here; the parent only strobes we/re for accepted requests.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: array contents survive reset, the parent's pointers make them unreachable
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: the output register holds the last word read and clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO (non-FWFT) with registered full/empty/data_out; optional sticky
// overflow/underflow flags under SYNC_FIFO_ERR_FLAGS_EN. Read latency: 1 cycle.
// Backpressure: writes rejected while full, reads rejected while empty; no state change.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OCC_W  = ADDR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0]  count_q;
    logic [OCC_W-1:0]  count_next;
    logic              full_q;
    logic              empty_q;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance is decided from the registered flags, so a full FIFO can still
    // take a read and an empty FIFO a write on the same edge
    always_comb begin
        wr_acc     = wr_en && !full_q;
        rd_acc     = rd_en && !empty_q;
        count_next = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + OCC_W'(1);
            2'b01:   count_next = count_q - OCC_W'(1);
            default: count_next = count_q;
        endcase
    end

    // Pointers, occupancy and flags; flags are precomputed from next-count so they
    // flip on the same edge the occupancy does
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == FULL_CNT);
            empty_q <= (count_next == '0);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc && !rst),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign full  = full_q;
    assign empty = empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags: set by any rejected request, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty_q) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
